// File: rtl/adma_dm_src_axis.sv
// DMA data-mover source side for AXI-Stream: emits exactly arlen+1 beats per descriptor, padding or draining on length mismatch.
// Optional build macro ADMA_SRC_AXIS_TKEEP_CHK_EN flags accepted beats with partial tkeep as source errors.
module adma_dm_src_axis #(
  parameter int DMA_CHN_NUM      = 4,
  parameter int MST_ID_W         = 5,
  parameter int ATX_LEN_W        = 8,
  parameter int ATX_SRC_DATA_W   = 256,
  parameter int ATX_SRC_BYTE_AMT = ATX_SRC_DATA_W / 8,
  parameter int ATX_NUM_OSTD     = DMA_CHN_NUM,
  parameter int DMA_CHN_NUM_W    = (DMA_CHN_NUM > 1) ? $clog2(DMA_CHN_NUM) : 1
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [DMA_CHN_NUM_W-1:0]    atx_chn_id,
  input  logic [ATX_LEN_W-1:0]        atx_arlen,
  input  logic                        atx_vld,
  output logic                        atx_rdy,
  output logic [ATX_SRC_DATA_W-1:0]   atx_rdata,
  output logic                        atx_rdata_vld,
  input  logic                        atx_rdata_rdy,
  output logic [DMA_CHN_NUM-1:0]      atx_done,
  output logic [DMA_CHN_NUM-1:0]      atx_src_err,
  input  logic [MST_ID_W-1:0]         s_tid_i,
  input  logic                        s_tdest_i,
  input  logic [ATX_SRC_DATA_W-1:0]   s_tdata_i,
  input  logic [ATX_SRC_BYTE_AMT-1:0] s_tkeep_i,
  input  logic [ATX_SRC_BYTE_AMT-1:0] s_tstrb_i,
  input  logic                        s_tlast_i,
  input  logic                        s_tvalid_i,
  output logic                        s_tready_o
);
  localparam int PTR_W = (ATX_NUM_OSTD > 1) ? $clog2(ATX_NUM_OSTD) : 1;
  localparam int CNT_W = $clog2(ATX_NUM_OSTD + 1);

  typedef enum logic [1:0] {IDLE, XFER, PAD, DRAIN} state_t;
  state_t state;

  logic [DMA_CHN_NUM_W-1:0] fifo_chn [ATX_NUM_OSTD];
  logic [ATX_LEN_W-1:0]     fifo_len [ATX_NUM_OSTD];
  logic [PTR_W-1:0]         wr_ptr, rd_ptr;
  logic [CNT_W-1:0]         fifo_cnt;
  logic                     init_q;
  logic [ATX_LEN_W-1:0]     beat_cnt;
  logic                     err_q, out_last, out_err;
  logic [DMA_CHN_NUM_W-1:0] out_chn;
  logic [DMA_CHN_NUM_W-1:0] head_chn;
  logic [ATX_LEN_W-1:0]     head_len;
  logic push, pop, loadable, beat_end, s_hs, keep_bad, fifo_avail, last_pend, start;
  logic unused_inputs;

  assign unused_inputs = ^{s_tid_i, s_tdest_i, s_tstrb_i, s_tkeep_i};

`ifdef ADMA_SRC_AXIS_TKEEP_CHK_EN
  assign keep_bad = (s_tkeep_i != '1);
`else
  assign keep_bad = 1'b0;
`endif

  assign atx_rdy  = init_q & (fifo_cnt != CNT_W'(ATX_NUM_OSTD));
  assign push     = atx_vld & atx_rdy;
  assign pop      = atx_rdata_vld & atx_rdata_rdy & out_last;
  assign loadable = ~atx_rdata_vld | atx_rdata_rdy;
  assign head_chn = fifo_chn[rd_ptr];
  assign head_len = fifo_len[rd_ptr];
  assign beat_end = (beat_cnt == head_len);
  assign s_hs     = s_tvalid_i & s_tready_o;

  // The head descriptor stays in the FIFO until its last beat leaves the output
  // register, so IDLE may only start once that beat is gone or leaving now.
  assign fifo_avail = pop ? (fifo_cnt > CNT_W'(1)) : (fifo_cnt != '0);
  assign last_pend  = atx_rdata_vld & out_last & ~atx_rdata_rdy;
  assign start      = fifo_avail & ~last_pend;

  always_comb begin
    case (state)
      XFER:    s_tready_o = loadable;
      DRAIN:   s_tready_o = 1'b1;
      default: s_tready_o = 1'b0;
    endcase
  end

  always_comb begin
    atx_done    = '0;
    atx_src_err = '0;
    if (pop) begin
      atx_done[out_chn]    = 1'b1;
      atx_src_err[out_chn] = out_err;
    end
  end

  always_ff @(posedge aclk) begin
    if (push) begin
      fifo_chn[wr_ptr] <= atx_chn_id;
      fifo_len[wr_ptr] <= atx_arlen;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      init_q   <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      init_q <= 1'b1;
      if (push) wr_ptr <= (wr_ptr == PTR_W'(ATX_NUM_OSTD - 1)) ? '0 : wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= (rd_ptr == PTR_W'(ATX_NUM_OSTD - 1)) ? '0 : rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state         <= IDLE;
      beat_cnt      <= '0;
      err_q         <= 1'b0;
      atx_rdata_vld <= 1'b0;
      atx_rdata     <= '0;
      out_last      <= 1'b0;
      out_err       <= 1'b0;
      out_chn       <= '0;
    end else begin
      if (atx_rdata_rdy) atx_rdata_vld <= 1'b0;
      case (state)
        IDLE: if (start) state <= XFER;
        XFER: if (s_hs) begin
          atx_rdata_vld <= 1'b1;
          atx_rdata     <= s_tdata_i;
          out_chn       <= head_chn;
          if (beat_end) begin
            beat_cnt <= '0;
            err_q    <= 1'b0;
            out_last <= 1'b1;
            out_err  <= ~s_tlast_i | err_q | keep_bad;
            state    <= s_tlast_i ? IDLE : DRAIN;
          end else begin
            beat_cnt <= beat_cnt + ATX_LEN_W'(1);
            out_last <= 1'b0;
            out_err  <= s_tlast_i | err_q | keep_bad;
            err_q    <= s_tlast_i | err_q | keep_bad;
            if (s_tlast_i) state <= PAD;
          end
        end
        PAD: if (loadable) begin
          atx_rdata_vld <= 1'b1;
          atx_rdata     <= '0;
          out_chn       <= head_chn;
          out_err       <= 1'b1;
          if (beat_end) begin
            beat_cnt <= '0;
            err_q    <= 1'b0;
            out_last <= 1'b1;
            state    <= IDLE;
          end else begin
            beat_cnt <= beat_cnt + ATX_LEN_W'(1);
            out_last <= 1'b0;
          end
        end
        DRAIN: if (s_hs && s_tlast_i) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_adma_dm_src_axis.sv
// Self-checking bench for adma_dm_src_axis: descriptor/stream drivers, output monitor and a packet-level reference model.
module tb_adma_dm_src_axis;
  localparam int DW = 256;
  localparam int BW = DW / 8;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic [1:0]    atx_chn_id;
  logic [7:0]    atx_arlen;
  logic          atx_vld, atx_rdy;
  logic [DW-1:0] atx_rdata;
  logic          atx_rdata_vld, atx_rdata_rdy;
  logic [3:0]    atx_done, atx_src_err;
  logic [4:0]    s_tid_i;
  logic          s_tdest_i;
  logic [DW-1:0] s_tdata_i;
  logic [BW-1:0] s_tkeep_i, s_tstrb_i;
  logic          s_tlast_i, s_tvalid_i, s_tready_o;

  adma_dm_src_axis #(
    .DMA_CHN_NUM(4), .MST_ID_W(5), .ATX_LEN_W(8), .ATX_SRC_DATA_W(DW),
    .ATX_SRC_BYTE_AMT(BW), .ATX_NUM_OSTD(4)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .atx_chn_id(atx_chn_id), .atx_arlen(atx_arlen), .atx_vld(atx_vld), .atx_rdy(atx_rdy),
    .atx_rdata(atx_rdata), .atx_rdata_vld(atx_rdata_vld), .atx_rdata_rdy(atx_rdata_rdy),
    .atx_done(atx_done), .atx_src_err(atx_src_err),
    .s_tid_i(s_tid_i), .s_tdest_i(s_tdest_i), .s_tdata_i(s_tdata_i), .s_tkeep_i(s_tkeep_i),
    .s_tstrb_i(s_tstrb_i), .s_tlast_i(s_tlast_i), .s_tvalid_i(s_tvalid_i), .s_tready_o(s_tready_o)
  );

  always #5 aclk = ~aclk;

  typedef struct { logic [1:0] chn; logic [7:0] len; } desc_t;
  typedef struct { logic [DW-1:0] data; logic [BW-1:0] keep; logic last; } sbeat_t;
  typedef struct { logic [DW-1:0] data; logic [3:0] done; logic [3:0] err; int cyc; } obeat_t;

  desc_t  dq[$];
  sbeat_t sq[$];
  obeat_t obs_q[$], exp_q[$];
  int     sfire_cyc[$], dfire_cyc[$];
  int     tests = 0, fails = 0, cyc = 0, stray = 0, busy_rdy = 0;
  int     rdy_mode = 0;
  bit     s_en = 1'b1, s_gap = 1'b0;
  logic   d_fire = 1'b0, s_fire = 1'b0;

  initial forever begin
    @(posedge aclk);
    cyc++;
  end

  // descriptor driver
  initial begin
    atx_vld = 1'b0; atx_chn_id = '0; atx_arlen = '0;
    forever begin
      @(posedge aclk); #1;
      if (d_fire) void'(dq.pop_front());
      if (dq.size() > 0) begin
        atx_vld = 1'b1; atx_chn_id = dq[0].chn; atx_arlen = dq[0].len;
      end else atx_vld = 1'b0;
    end
  end

  // stream driver
  initial begin
    s_tvalid_i = 1'b0; s_tdata_i = '0; s_tkeep_i = '1; s_tlast_i = 1'b0;
    s_tid_i = 5'h3; s_tdest_i = 1'b0; s_tstrb_i = '1;
    forever begin
      @(posedge aclk); #1;
      if (s_fire) void'(sq.pop_front());
      if (sq.size() > 0) begin
        s_tdata_i = sq[0].data; s_tkeep_i = sq[0].keep; s_tlast_i = sq[0].last;
      end
      s_tvalid_i = s_en && (sq.size() > 0) && (!s_gap || ($urandom_range(0, 3) != 0));
    end
  end

  // output sink
  initial begin
    atx_rdata_rdy = 1'b1;
    forever begin
      @(posedge aclk); #1;
      case (rdy_mode)
        0:       atx_rdata_rdy = 1'b1;
        1:       atx_rdata_rdy = ~atx_rdata_rdy;
        default: atx_rdata_rdy = ($urandom_range(0, 2) != 0);
      endcase
    end
  end

  // monitor
  initial forever begin
    @(negedge aclk);
    d_fire = atx_vld & atx_rdy;
    s_fire = s_tvalid_i & s_tready_o;
    if (d_fire) dfire_cyc.push_back(cyc);
    if (s_fire) sfire_cyc.push_back(cyc);
    if (atx_rdata_vld && atx_rdata_rdy)
      obs_q.push_back('{data: atx_rdata, done: atx_done, err: atx_src_err, cyc: cyc});
    else if ((atx_done | atx_src_err) != 4'b0) stray++;
    if (s_tready_o && atx_rdata_vld && !atx_rdata_rdy) busy_rdy++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Reference model: a packet of plen beats against a descriptor of arlen+1 beats
  // yields min(plen,n) stream beats, zero fill to n, err on length mismatch.
  task automatic plan(input int chn, input int arlen, input int plen, input int kbad);
    int n;
    bit err;
    logic [DW-1:0] d;
    logic [DW-1:0] dd[$];
    n = arlen + 1;
    err = (plen != n);
`ifdef ADMA_SRC_AXIS_TKEEP_CHK_EN
    if (kbad >= 0 && kbad < plen && kbad < n) err = 1'b1;
`endif
    for (int i = 0; i < plen; i++) begin
      for (int j = 0; j < DW / 32; j++) d[j*32 +: 32] = $urandom();
      dd.push_back(d);
      sq.push_back('{data: d, keep: (i == kbad) ? 32'h0000FFFF : 32'hFFFFFFFF, last: (i == plen - 1)});
    end
    for (int i = 0; i < n; i++)
      exp_q.push_back('{data: (i < plen) ? dd[i] : '0,
                        done: (i == n - 1) ? (4'b1 << chn) : 4'b0,
                        err:  (i == n - 1 && err) ? (4'b1 << chn) : 4'b0, cyc: 0});
    dq.push_back('{chn: 2'(chn), len: 8'(arlen)});
  endtask

  task automatic start_test();
    obs_q.delete(); exp_q.delete(); sfire_cyc.delete(); dfire_cyc.delete();
    stray = 0; busy_rdy = 0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge aclk); #1;
      if (obs_q.size() >= exp_q.size() && dq.size() == 0 && sq.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (4) @(negedge aclk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge aclk);
    tests++; if (atx_rdy !== 1'b0) begin fails++; $display("FAIL reset_atx_rdy: got %b want 0", atx_rdy); end
    tests++; if (atx_rdata_vld !== 1'b0) begin fails++; $display("FAIL reset_rdata_vld: got %b want 0", atx_rdata_vld); end
    tests++; if (atx_rdata !== '0) begin fails++; $display("FAIL reset_rdata: got %h want 0", atx_rdata); end
    tests++; if (s_tready_o !== 1'b0) begin fails++; $display("FAIL reset_tready: got %b want 0", s_tready_o); end
    tests++; if (atx_done !== 4'b0) begin fails++; $display("FAIL reset_done: got %b want 0000", atx_done); end
    tests++; if (atx_src_err !== 4'b0) begin fails++; $display("FAIL reset_err: got %b want 0000", atx_src_err); end
    @(posedge aclk); #1;
    aresetn = 1'b1;
    repeat (2) @(negedge aclk);
    tests++; if (atx_rdy !== 1'b1) begin fails++; $display("FAIL post_reset_atx_rdy: got %b want 1", atx_rdy); end
  endtask

  task automatic test_basic();
    bit ok;
    start_test(); rdy_mode = 0; s_gap = 1'b0;
    plan(2, 3, 4, -1);
    wait_idle(200, ok);
    tests++; if (!ok) begin fails++; $display("FAIL basic_timeout: got %0d beats want %0d", obs_q.size(), exp_q.size()); end
    tests++; if (obs_q.size() !== exp_q.size()) begin fails++; $display("FAIL basic_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      tests++;
      if (i >= obs_q.size() || obs_q[i].data !== exp_q[i].data || obs_q[i].done !== exp_q[i].done || obs_q[i].err !== exp_q[i].err) begin
        fails++;
        if (i < obs_q.size()) $display("FAIL basic_beat%0d: got data=%h done=%b err=%b want data=%h done=%b err=%b", i, obs_q[i].data, obs_q[i].done, obs_q[i].err, exp_q[i].data, exp_q[i].done, exp_q[i].err);
        else $display("FAIL basic_beat%0d: got no beat want data=%h", i, exp_q[i].data);
      end
    end
    for (int i = 0; i < 4; i++) begin
      int got, want;
      got  = (i < obs_q.size()) ? obs_q[i].cyc : -1;
      want = (i < sfire_cyc.size()) ? sfire_cyc[i] + 1 : -2;
      tests++; if (got !== want) begin fails++; $display("FAIL basic_latency%0d: got cycle %0d want %0d", i, got, want); end
    end
    tests++; if (stray !== 0) begin fails++; $display("FAIL basic_stray_done: got %0d want 0", stray); end
  endtask

  task automatic test_short();
    bit ok;
    start_test(); rdy_mode = 0; s_gap = 1'b0;
    plan(1, 3, 2, -1);
    plan(3, 0, 1, -1);
    wait_idle(200, ok);
    tests++; if (!ok) begin fails++; $display("FAIL short_timeout: got %0d beats want %0d", obs_q.size(), exp_q.size()); end
    tests++; if (obs_q.size() !== exp_q.size()) begin fails++; $display("FAIL short_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      tests++;
      if (i >= obs_q.size() || obs_q[i].data !== exp_q[i].data || obs_q[i].done !== exp_q[i].done || obs_q[i].err !== exp_q[i].err) begin
        fails++;
        if (i < obs_q.size()) $display("FAIL short_beat%0d: got data=%h done=%b err=%b want data=%h done=%b err=%b", i, obs_q[i].data, obs_q[i].done, obs_q[i].err, exp_q[i].data, exp_q[i].done, exp_q[i].err);
        else $display("FAIL short_beat%0d: got no beat want data=%h", i, exp_q[i].data);
      end
    end
    tests++; if (sfire_cyc.size() !== 3) begin fails++; $display("FAIL short_stream_beats: got %0d want 3", sfire_cyc.size()); end
  endtask

  task automatic test_long();
    bit ok;
    start_test(); rdy_mode = 0; s_gap = 1'b0;
    plan(0, 1, 5, -1);
    plan(2, 1, 2, -1);
    wait_idle(200, ok);
    tests++; if (!ok) begin fails++; $display("FAIL long_timeout: got %0d beats want %0d", obs_q.size(), exp_q.size()); end
    tests++; if (obs_q.size() !== exp_q.size()) begin fails++; $display("FAIL long_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      tests++;
      if (i >= obs_q.size() || obs_q[i].data !== exp_q[i].data || obs_q[i].done !== exp_q[i].done || obs_q[i].err !== exp_q[i].err) begin
        fails++;
        if (i < obs_q.size()) $display("FAIL long_beat%0d: got data=%h done=%b err=%b want data=%h done=%b err=%b", i, obs_q[i].data, obs_q[i].done, obs_q[i].err, exp_q[i].data, exp_q[i].done, exp_q[i].err);
        else $display("FAIL long_beat%0d: got no beat want data=%h", i, exp_q[i].data);
      end
    end
    tests++; if (sfire_cyc.size() !== 7) begin fails++; $display("FAIL long_stream_beats: got %0d want 7", sfire_cyc.size()); end
  endtask

  task automatic test_fifo_full();
    bit ok;
    int got, want;
    start_test(); rdy_mode = 0; s_gap = 1'b0; s_en = 1'b0;
    plan(0, 1, 2, -1);
    plan(1, 1, 2, -1);
    plan(2, 1, 2, -1);
    plan(3, 1, 2, -1);
    plan(1, 0, 1, -1);
    repeat (12) @(negedge aclk);
    #1;
    tests++; if (dfire_cyc.size() !== 4) begin fails++; $display("FAIL fifo_accepted: got %0d want 4", dfire_cyc.size()); end
    tests++; if (atx_rdy !== 1'b0) begin fails++; $display("FAIL fifo_full_rdy: got %b want 0", atx_rdy); end
    s_en = 1'b1;
    wait_idle(300, ok);
    tests++; if (!ok) begin fails++; $display("FAIL fifo_timeout: got %0d beats want %0d", obs_q.size(), exp_q.size()); end
    tests++; if (obs_q.size() !== exp_q.size()) begin fails++; $display("FAIL fifo_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      tests++;
      if (i >= obs_q.size() || obs_q[i].data !== exp_q[i].data || obs_q[i].done !== exp_q[i].done || obs_q[i].err !== exp_q[i].err) begin
        fails++;
        if (i < obs_q.size()) $display("FAIL fifo_beat%0d: got data=%h done=%b err=%b want data=%h done=%b err=%b", i, obs_q[i].data, obs_q[i].done, obs_q[i].err, exp_q[i].data, exp_q[i].done, exp_q[i].err);
        else $display("FAIL fifo_beat%0d: got no beat want data=%h", i, exp_q[i].data);
      end
    end
    got  = (dfire_cyc.size() > 4) ? dfire_cyc[4] : -1;
    want = (obs_q.size() > 1) ? obs_q[1].cyc + 1 : -2;
    tests++; if (got !== want) begin fails++; $display("FAIL fifo_fifth_accept: got cycle %0d want %0d", got, want); end
    got  = (obs_q.size() > 2) ? obs_q[2].cyc : -1;
    want = (obs_q.size() > 1) ? obs_q[1].cyc + 2 : -2;
    tests++; if (got !== want) begin fails++; $display("FAIL fifo_bubble: got cycle %0d want %0d", got, want); end
  endtask

  task automatic test_backpressure();
    bit ok;
    start_test(); rdy_mode = 1; s_gap = 1'b0;
    plan(3, 3, 4, -1);
    wait_idle(200, ok);
    rdy_mode = 0;
    tests++; if (!ok) begin fails++; $display("FAIL bp_timeout: got %0d beats want %0d", obs_q.size(), exp_q.size()); end
    tests++; if (obs_q.size() !== exp_q.size()) begin fails++; $display("FAIL bp_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      tests++;
      if (i >= obs_q.size() || obs_q[i].data !== exp_q[i].data || obs_q[i].done !== exp_q[i].done || obs_q[i].err !== exp_q[i].err) begin
        fails++;
        if (i < obs_q.size()) $display("FAIL bp_beat%0d: got data=%h done=%b err=%b want data=%h done=%b err=%b", i, obs_q[i].data, obs_q[i].done, obs_q[i].err, exp_q[i].data, exp_q[i].done, exp_q[i].err);
        else $display("FAIL bp_beat%0d: got no beat want data=%h", i, exp_q[i].data);
      end
    end
    tests++; if (busy_rdy !== 0) begin fails++; $display("FAIL bp_tready_when_full: got %0d cycles want 0", busy_rdy); end
  endtask

  task automatic test_tkeep();
    bit ok;
    logic [3:0] want_err;
`ifdef ADMA_SRC_AXIS_TKEEP_CHK_EN
    want_err = 4'b0001;
`else
    want_err = 4'b0000;
`endif
    start_test(); rdy_mode = 0; s_gap = 1'b0;
    plan(0, 3, 4, 1);
    wait_idle(200, ok);
    tests++; if (!ok) begin fails++; $display("FAIL tkeep_timeout: got %0d beats want %0d", obs_q.size(), exp_q.size()); end
    tests++; if (obs_q.size() !== 4) begin fails++; $display("FAIL tkeep_count: got %0d want 4", obs_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      tests++;
      if (i >= obs_q.size() || obs_q[i].data !== exp_q[i].data || obs_q[i].done !== exp_q[i].done) begin
        fails++;
        if (i < obs_q.size()) $display("FAIL tkeep_beat%0d: got data=%h done=%b want data=%h done=%b", i, obs_q[i].data, obs_q[i].done, exp_q[i].data, exp_q[i].done);
        else $display("FAIL tkeep_beat%0d: got no beat want data=%h", i, exp_q[i].data);
      end
    end
    tests++;
    if (obs_q.size() < 4 || obs_q[3].err !== want_err) begin
      fails++;
      $display("FAIL tkeep_err: got %b want %b", (obs_q.size() > 3) ? obs_q[3].err : 4'bxxxx, want_err);
    end
  endtask

  task automatic test_random();
    bit ok;
    int a, l, k;
    start_test(); rdy_mode = 2; s_gap = 1'b1;
    for (int t = 0; t < 24; t++) begin
      a = $urandom_range(0, 6);
      l = ($urandom_range(0, 2) == 0) ? a + 1 : $urandom_range(1, 9);
      k = ($urandom_range(0, 3) == 0) ? $urandom_range(0, l - 1) : -1;
      plan($urandom_range(0, 3), a, l, k);
    end
    wait_idle(6000, ok);
    rdy_mode = 0; s_gap = 1'b0;
    tests++; if (!ok) begin fails++; $display("FAIL rand_timeout: got %0d beats want %0d", obs_q.size(), exp_q.size()); end
    tests++; if (obs_q.size() !== exp_q.size()) begin fails++; $display("FAIL rand_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      tests++;
      if (i >= obs_q.size() || obs_q[i].data !== exp_q[i].data || obs_q[i].done !== exp_q[i].done || obs_q[i].err !== exp_q[i].err) begin
        fails++;
        if (i < obs_q.size()) $display("FAIL rand_beat%0d: got data=%h done=%b err=%b want data=%h done=%b err=%b", i, obs_q[i].data, obs_q[i].done, obs_q[i].err, exp_q[i].data, exp_q[i].done, exp_q[i].err);
        else $display("FAIL rand_beat%0d: got no beat want data=%h", i, exp_q[i].data);
      end
    end
    tests++; if (stray !== 0) begin fails++; $display("FAIL rand_stray_done: got %0d want 0", stray); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_short();
    test_long();
    test_fifo_full();
    test_backpressure();
    test_tkeep();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
